// File: rtl/ibex_rf_wr_arbiter.sv
// ibex_rf_wr_arbiter
// Shares the single register-file write port between EX writeback and LSU
// load writeback (round-robin on conflict). After every reset an optional
// sweep writes InitValue to registers 1..NUM_WORDS-1. The write port is
// driven from a registered output stage.

module ibex_rf_wr_arbiter #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter bit                   InitOnReset = 1'b1,
  parameter logic [DataWidth-1:0] InitValue   = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 ex_valid_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,

  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_ready_o,

  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,

  output logic                 init_busy_o,
  output logic                 illegal_waddr_o
);

  localparam int unsigned NumWords = RV32E ? 16 : 32;
  localparam logic [4:0]  LastAddr = 5'(NumWords - 1);

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam state_e ResetState = InitOnReset ? StInit : StRun;

  state_e               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 prio_q, prio_d;
  logic                 rf_we_q, rf_we_d;
  logic [4:0]           rf_waddr_q, rf_waddr_d;
  logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;
  logic                 illegal_q, illegal_d;

  logic                 is_run_s;
  logic                 grant_ex_s;
  logic                 grant_lsu_s;
  logic                 accept_s;
  logic [4:0]           acc_waddr_s;
  logic [DataWidth-1:0] acc_wdata_s;
  logic                 acc_illegal_s;

  // Ready is suppressed while reset is held, even when the FSM resets into RUN.
  assign is_run_s = (state_q == StRun) & ~rst_i;

  // Arbitration depends only on the valids and the pointer, never on addr/data.
  assign grant_ex_s  = ex_valid_i  & (~lsu_valid_i | ~prio_q);
  assign grant_lsu_s = lsu_valid_i & (~ex_valid_i  |  prio_q);
  assign accept_s    = grant_ex_s | grant_lsu_s;

  assign ex_ready_o  = is_run_s & grant_ex_s;
  assign lsu_ready_o = is_run_s & grant_lsu_s;

  assign acc_waddr_s   = grant_ex_s ? ex_waddr_i : lsu_waddr_i;
  assign acc_wdata_s   = grant_ex_s ? ex_wdata_i : lsu_wdata_i;
  // Only the 16-register configuration has addresses outside the file.
  assign acc_illegal_s = RV32E & acc_waddr_s[4];

  // Next-state logic for the sweep/run FSM, the pointer and the output stage.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prio_d     = prio_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    illegal_d  = 1'b0;

    case (state_q)
      StInit: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = cnt_q;
        rf_wdata_d = InitValue;
        cnt_d      = cnt_q + 5'd1;
        if (cnt_q == LastAddr) begin
          state_d = StRun;
        end else begin
          state_d = StInit;
        end
      end

      StRun: begin
        // On a conflict the winner was prio_q, so toggling points at the loser.
        if (ex_valid_i & lsu_valid_i) begin
          prio_d = ~prio_q;
        end else begin
          prio_d = prio_q;
        end

        if (accept_s) begin
          if (acc_illegal_s) begin
            illegal_d = 1'b1;
          end else if (acc_waddr_s != 5'd0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = acc_waddr_s;
            rf_wdata_d = acc_wdata_s;
          end else begin
            // x0 is hard-wired: handshake completes with no write.
            rf_we_d = 1'b0;
          end
        end else begin
          rf_we_d = 1'b0;
        end
      end

      default: begin
        state_d = ResetState;
      end
    endcase
  end

  // State and output registers; reset discards any pending write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ResetState;
      cnt_q      <= 5'd1;
      prio_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prio_q     <= prio_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      illegal_q  <= illegal_d;
    end
  end

  assign rf_we_o         = rf_we_q;
  assign rf_waddr_o      = rf_waddr_q;
  assign rf_wdata_o      = rf_wdata_q;
  assign illegal_waddr_o = illegal_q;
  assign init_busy_o     = (state_q == StInit);

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
// Self-checking bench for ibex_rf_wr_arbiter: scoreboard of expected
// output-stage writes, pushed when a cycle's stimulus is sampled and popped
// one edge later when the DUT presents it.

module tb_ibex_rf_wr_arbiter;

  localparam logic [31:0] INIT_VAL   = 32'hDEAD_BEEF;
  localparam logic [31:0] INIT_VAL16 = 32'h0000_1234;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst16 = 1'b1;

  logic        ex_valid = 1'b0;
  logic [4:0]  ex_waddr = 5'd0;
  logic [31:0] ex_wdata = 32'd0;
  logic        ex_ready;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_waddr = 5'd0;
  logic [31:0] lsu_wdata = 32'd0;
  logic        lsu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        init_busy;
  logic        illegal;

  logic        l16_valid = 1'b0;
  logic [4:0]  l16_waddr = 5'd0;
  logic [31:0] l16_wdata = 32'd0;
  logic        e16_ready, l16_ready, we16, busy16, ill16;
  logic [4:0]  waddr16;
  logic [31:0] wdata16;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ill;
  } wr_t;

  wr_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // bench model state
  logic       m_init = 1'b1;
  logic [4:0] m_cnt  = 5'd1;
  logic       m_prio = 1'b0;

  always #5 clk = ~clk;

  ibex_rf_wr_arbiter #(
    .RV32E(1'b0), .DataWidth(32), .InitOnReset(1'b1), .InitValue(INIT_VAL)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready),
    .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata), .lsu_ready_o(lsu_ready),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .init_busy_o(init_busy), .illegal_waddr_o(illegal)
  );

  ibex_rf_wr_arbiter #(
    .RV32E(1'b1), .DataWidth(32), .InitOnReset(1'b1), .InitValue(INIT_VAL16)
  ) dut16 (
    .clk_i(clk), .rst_i(rst16),
    .ex_valid_i(1'b0), .ex_waddr_i(5'd0), .ex_wdata_i(32'd0), .ex_ready_o(e16_ready),
    .lsu_valid_i(l16_valid), .lsu_waddr_i(l16_waddr), .lsu_wdata_i(l16_wdata), .lsu_ready_o(l16_ready),
    .rf_we_o(we16), .rf_waddr_o(waddr16), .rf_wdata_o(wdata16),
    .init_busy_o(busy16), .illegal_waddr_o(ill16)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One cycle: called at posedge+1 with inputs already set; returns grants.
  task automatic step(output logic a_ex, output logic a_lsu);
    wr_t e;
    logic exp_ex, exp_lsu;
    @(negedge clk);
    e = '0;
    if (m_init) begin
      exp_ex  = 1'b0;
      exp_lsu = 1'b0;
      check_eq("init_busy_hi", {31'd0, init_busy}, 32'd1);
      e.we   = 1'b1;
      e.addr = m_cnt;
      e.data = INIT_VAL;
      if (m_cnt == 5'd31) m_init = 1'b0;
      m_cnt = m_cnt + 5'd1;
    end else begin
      check_eq("init_busy_lo", {31'd0, init_busy}, 32'd0);
      exp_ex  = ex_valid  & (~lsu_valid | ~m_prio);
      exp_lsu = lsu_valid & (~ex_valid  |  m_prio);
      if (ex_valid & lsu_valid) m_prio = ~m_prio;
      if (exp_ex) begin
        e.we = (ex_waddr != 5'd0); e.addr = ex_waddr; e.data = ex_wdata;
      end else if (exp_lsu) begin
        e.we = (lsu_waddr != 5'd0); e.addr = lsu_waddr; e.data = lsu_wdata;
      end
    end
    check_eq("ex_ready", {31'd0, ex_ready}, {31'd0, exp_ex});
    check_eq("lsu_ready", {31'd0, lsu_ready}, {31'd0, exp_lsu});
    a_ex  = ex_ready;
    a_lsu = lsu_ready;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("rf_we", {31'd0, rf_we}, {31'd0, e.we});
    check_eq("illegal", {31'd0, illegal}, {31'd0, e.ill});
    if (e.we) begin
      check_eq("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.addr});
      check_eq("rf_wdata", rf_wdata, e.data);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_we"}, {31'd0, rf_we}, 32'd0);
    check_eq({tag, "_waddr"}, {27'd0, rf_waddr}, 32'd0);
    check_eq({tag, "_wdata"}, rf_wdata, 32'd0);
    check_eq({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, init_busy}, 32'd1);
    check_eq({tag, "_ex_rdy"}, {31'd0, ex_ready}, 32'd0);
    check_eq({tag, "_lsu_rdy"}, {31'd0, lsu_ready}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic a_ex, a_lsu, got;
    logic [7:0] order;

    // Reset state, with an EX request already pending (held through sweep).
    ex_valid = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'h33;
    #2;
    check_zero_outputs("reset");

    @(posedge clk); #1;
    rst = 1'b0;

    // Full 31-write sweep, then the held request is accepted.
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(a_ex, a_lsu);
      got = a_ex;
    end
    check_eq("first_accept", {31'd0, got}, 32'd1);
    ex_valid = 1'b0;

    // Conflict: both held for 4 cycles -> EX, LSU, EX, LSU.
    ex_valid  = 1'b1; ex_waddr  = 5'd5; ex_wdata  = 32'hA;
    lsu_valid = 1'b1; lsu_waddr = 5'd6; lsu_wdata = 32'hB;
    order = 8'd0;
    for (int i = 0; i < 4; i++) begin
      step(a_ex, a_lsu);
      order = {order[5:0], a_ex, a_lsu};
    end
    check_eq("conflict_order", {24'd0, order}, {24'd0, 8'b10_01_10_01});
    ex_valid = 1'b0; lsu_valid = 1'b0;

    // EX back-to-back x1..x8, data = address.
    for (int i = 1; i <= 8; i++) begin
      ex_valid = 1'b1; ex_waddr = 5'(i); ex_wdata = 32'(i);
      step(a_ex, a_lsu);
      check_eq("b2b_accept", {31'd0, a_ex}, 32'd1);
    end

    // Write to x0: handshake, no write, no error.
    ex_waddr = 5'd0; ex_wdata = 32'hFFFF_FFFF;
    step(a_ex, a_lsu);
    check_eq("x0_accept", {31'd0, a_ex}, 32'd1);
    ex_valid = 1'b0;
    step(a_ex, a_lsu);

    // LSU alone, then reset while its write sits in the output register.
    lsu_valid = 1'b1; lsu_waddr = 5'd7; lsu_wdata = 32'h77;
    step(a_ex, a_lsu);
    check_eq("lsu_accept", {31'd0, a_lsu}, 32'd1);
    lsu_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    m_init = 1'b1; m_cnt = 5'd1; m_prio = 1'b0;
    #1;
    check_zero_outputs("rst_run");
    @(posedge clk); #1;
    rst = 1'b0;

    // Sweep up to register 10, then reset mid-sweep.
    for (int i = 0; i < 10; i++) step(a_ex, a_lsu);
    check_eq("sweep_at_10", {27'd0, rf_waddr}, 32'd10);
    rst = 1'b1;
    exp_q.delete();
    m_init = 1'b1; m_cnt = 5'd1; m_prio = 1'b0;
    #1;
    check_zero_outputs("rst_sweep");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 31; i++) step(a_ex, a_lsu);
    ex_valid = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'h99;
    step(a_ex, a_lsu);
    check_eq("after_resweep_accept", {31'd0, a_ex}, 32'd1);
    ex_valid = 1'b0;

    // RV32E instance: 15-write sweep, then illegal address 20 from LSU.
    l16_valid = 1'b1; l16_waddr = 5'd20; l16_wdata = 32'h5;
    rst16 = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      check_eq("e_sweep_we", {31'd0, we16}, 32'd1);
      check_eq("e_sweep_addr", {27'd0, waddr16}, 32'(i));
      check_eq("e_sweep_data", wdata16, INIT_VAL16);
      if (i < 15) begin
        check_eq("e_sweep_busy", {31'd0, busy16}, 32'd1);
        check_eq("e_sweep_rdy", {31'd0, l16_ready}, 32'd0);
      end else begin
        check_eq("e_done_busy", {31'd0, busy16}, 32'd0);
        check_eq("e_done_rdy", {31'd0, l16_ready}, 32'd1);
      end
    end
    @(posedge clk); #1;
    l16_valid = 1'b0;
    check_eq("e_ill_we", {31'd0, we16}, 32'd0);
    check_eq("e_ill_pulse", {31'd0, ill16}, 32'd1);
    @(posedge clk); #1;
    check_eq("e_ill_clear", {31'd0, ill16}, 32'd0);
    check_eq("e_idle_we", {31'd0, we16}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
